uart_rx_cmd: RTL

- Receive-side command parser for the lab UART link.
- Consumes bytes from the UART receiver (rx_byte/received) and parses host text lines of the form "R<n>:<hex>" terminated by CR or LF.
- Emits one register-write command (register number plus data word) toward the sequencer per well-formed line.
- Mirrors the transmit-side formatter, which emits "R<n>:<hex>\r\n".

---
 rtl/uart_rx_cmd_pkg.sv | 18 +
 rtl/uart_rx_cmd.sv | 107 ++++++++++
 2 files changed

// File: rtl/uart_rx_cmd_pkg.sv
// uart_rx_cmd_pkg: shared sequencer widths, ASCII constants and hex helpers
package uart_rx_cmd_pkg;
  localparam int seq_dp_width = 8;
  localparam logic [7:0] asc_r = 8'h52;
  localparam logic [7:0] asc_r_lc = 8'h72;
  localparam logic [7:0] asc_colon = 8'h3A;
  localparam logic [7:0] asc_cr = 8'h0D;
  localparam logic [7:0] asc_lf = 8'h0A;
  function automatic logic [7:0] fnNib2ASCII(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : 8'h37 + {4'h0, n};
  endfunction
  function automatic logic fnIsHex(input logic [7:0] c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction
  function automatic logic [3:0] fnASCII2Nib(input logic [7:0] c);
    return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
  endfunction
endpackage

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: parses "R<n>:<hex>" lines from the UART receiver into register-write commands
module uart_rx_cmd
  import uart_rx_cmd_pkg::*;
#(
  parameter int dp_width = seq_dp_width,
  parameter int num_nib = dp_width / 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  output logic [1:0]          o_cmd_regnum,
  output logic [dp_width-1:0] o_cmd_data,
  output logic                o_cmd_stb,
  output logic                o_err,
  output logic                o_busy
);
  localparam int cw = $clog2(num_nib + 1);
  localparam logic [cw-1:0] max_cnt = cw'(num_nib);
  typedef enum logic [2:0] {stIdle, stRegNum, stColon, stHex, stErr} state_t;
  state_t state, state_n;
  logic [dp_width-1:0] acc, acc_n;
  logic [cw-1:0] cnt, cnt_n;
  logic [1:0] reg_q, reg_n;
  logic stb_n, err_n;
  logic is_term, is_r, is_reg, is_hex;
  assign is_term = (i_rx_data == asc_cr) || (i_rx_data == asc_lf);
  assign is_r = (i_rx_data == asc_r) || (i_rx_data == asc_r_lc);
  assign is_reg = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h33);
  assign is_hex = fnIsHex(i_rx_data);
  assign o_busy = state != stIdle;
  always_comb begin
    state_n = state;
    acc_n = acc;
    cnt_n = cnt;
    reg_n = reg_q;
    stb_n = 1'b0;
    err_n = 1'b0;
    if (i_rx_valid) begin
      case (state)
        stIdle: begin
          if (is_r) state_n = stRegNum;
          else if (!is_term) begin
            state_n = stErr;
            err_n = 1'b1;
          end
        end
        stRegNum: begin
          if (is_reg) begin
            reg_n = i_rx_data[1:0];
            state_n = stColon;
          end else begin
            state_n = is_term ? stIdle : stErr;
            err_n = 1'b1;
          end
        end
        stColon: begin
          if (i_rx_data == asc_colon) begin
            state_n = stHex;
            acc_n = '0;
            cnt_n = '0;
          end else begin
            state_n = is_term ? stIdle : stErr;
            err_n = 1'b1;
          end
        end
        stHex: begin
          if (is_hex && cnt != max_cnt) begin
            acc_n = dp_width'({acc, fnASCII2Nib(i_rx_data)});
            cnt_n = cnt + 1'b1;
          end else if (is_term && cnt != '0) begin
            state_n = stIdle;
            stb_n = 1'b1;
          end else begin
            state_n = is_term ? stIdle : stErr;
            err_n = 1'b1;
          end
        end
        stErr: state_n = is_term ? stIdle : stErr;
        default: state_n = stIdle;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= stIdle;
      acc <= '0;
      cnt <= '0;
      reg_q <= '0;
      o_cmd_stb <= 1'b0;
      o_err <= 1'b0;
      o_cmd_data <= '0;
      o_cmd_regnum <= '0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      reg_q <= reg_n;
      o_cmd_stb <= stb_n;
      o_err <= err_n;
      if (stb_n) begin
        o_cmd_data <= acc;
        o_cmd_regnum <= reg_q;
      end
    end
  end
endmodule
